bit_vector_assembler: RTL and testbench

Upstream feeder for the 255-bit population counter. Accepts a narrow stream of CHUNK_W-bit beats over a valid/ready handshake and packs them LSB-first into a VEC_W-bit vector. When the vector is complete, or when the stream is terminated early, it presents the vector to the counter stage through a second valid/ready handshake. The popcount stage consumes out_vec directly.

---
 rtl/bit_vector_assembler.sv | 115 +++++++++++
 tb/tb_bit_vector_assembler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bit_vector_assembler.sv
// rtl/bit_vector_assembler.sv - packs CHUNK_W-bit beats LSB-first into a VEC_W-bit vector
//
// Purpose:
//   Feeder for the population counter. Beats arriving on the in_* handshake
//   are written at ascending chunk positions of an internal vector. After
//   NUM_BEATS beats, or on an earlier beat tagged in_last, the vector is held
//   on the out_* handshake until the downstream stage takes it.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_data    - beat payload (CHUNK_W bits)
//   in_valid   - beat offered
//   in_last    - final beat of the vector, qualified by in_valid
//   in_ready   - assembler accepts a beat (high only while filling)
//   out_vec    - assembled vector (VEC_W bits)
//   out_valid  - out_vec complete and stable
//   out_ready  - downstream accepts out_vec
//   out_beats  - number of beats that formed out_vec

module bit_vector_assembler #(
    parameter int VEC_W   = 255,
    parameter int CHUNK_W = 8
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [CHUNK_W-1:0]                              in_data,
    input  logic                                            in_valid,
    input  logic                                            in_last,
    output logic                                            in_ready,
    output logic [VEC_W-1:0]                                out_vec,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [$clog2(((VEC_W+CHUNK_W-1)/CHUNK_W)+1)-1:0] out_beats
);

    localparam int NUM_BEATS = (VEC_W + CHUNK_W - 1) / CHUNK_W;
    localparam int BEAT_W    = $clog2(NUM_BEATS + 1);
    // The last beat may overhang the vector; the staging word is wide enough
    // to take every beat whole, and the overhang is dropped on the way back.
    localparam int WIDE_W    = NUM_BEATS * CHUNK_W;

    localparam logic [BEAT_W-1:0] LAST_IDX = BEAT_W'(NUM_BEATS - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [VEC_W-1:0]    vec_q,   vec_d;
    logic [BEAT_W-1:0]   idx_q,   idx_d;
    logic [BEAT_W-1:0]   beats_q, beats_d;
    logic [WIDE_W-1:0]   wide;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        idx_d   = idx_q;
        beats_d = beats_q;
        wide    = WIDE_W'(vec_q);

        case (state_q)
            FILL: begin
                if (in_valid) begin
                    // Constant-index decode of the beat position keeps every
                    // slice static.
                    for (int b = 0; b < NUM_BEATS; b++) begin
                        if (idx_q == BEAT_W'(b)) begin
                            wide[b*CHUNK_W +: CHUNK_W] = in_data;
                        end
                    end
                    vec_d = wide[VEC_W-1:0];
                    idx_d = idx_q + BEAT_W'(1);
                    if ((idx_q == LAST_IDX) || in_last) begin
                        state_d = HOLD;
                        beats_d = idx_q + BEAT_W'(1);
                    end
                end
            end
            HOLD: begin
                // Clearing here is what zeroes the untouched upper chunks of
                // an early-terminated vector.
                if (out_ready) begin
                    state_d = FILL;
                    vec_d   = '0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            vec_q   <= '0;
            idx_q   <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            idx_q   <= idx_d;
            beats_q <= beats_d;
        end
    end

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == HOLD);
    assign out_vec   = vec_q;
    assign out_beats = beats_q;

endmodule

// File: tb/tb_bit_vector_assembler.sv
// tb/tb_bit_vector_assembler.sv - directed self-checking bench for bit_vector_assembler

module tb_bit_vector_assembler;

    logic         clk;
    logic         rst_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [254:0] out_vec;
    logic         out_valid;
    logic         out_ready;
    logic [5:0]   out_beats;

    int total;
    int bad;

    bit_vector_assembler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_vec   (out_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_beats (out_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [254:0] rep_byte(input logic [7:0] b);
        logic [255:0] t;
        for (int k = 0; k < 32; k++) t[k*8 +: 8] = b;
        return t[254:0];
    endfunction

    // Inputs change 1 time unit after a rising edge; ready is sampled on the
    // falling edge before the accepting edge.
    task automatic send_beat(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("beat_timeout", 256'(in_ready), 256'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_n(input int n, input logic [7:0] d, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 1) begin
                    in_valid = 1'b0;
                    in_data  = 8'hFF;
                    @(posedge clk);
                    #1;
                end
            end
            send_beat(d, 1'b0);
        end
    endtask

    task automatic expect_vec(input string tag, input logic [254:0] v, input int beats, input int ones);
        // Called 1 time unit after the final accepting edge: out_valid must
        // already be up.
        check({tag, "_valid"}, 256'(out_valid), 256'(1));
        check({tag, "_vec"},   {1'b0, out_vec}, {1'b0, v});
        check({tag, "_beats"}, 256'(out_beats), 256'(beats));
        check({tag, "_pop"},   256'($countones(out_vec)), 256'(ones));
        check({tag, "_ready"}, 256'(in_ready), 256'(0));
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drain_valid"}, 256'(out_valid), 256'(0));
        check({tag, "_drain_ready"}, 256'(in_ready), 256'(1));
        check({tag, "_drain_vec"},   {1'b0, out_vec}, 256'(0));
    endtask

    initial begin
        logic [254:0] held_vec;
        logic [254:0] exp_v;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 256'(out_valid), 256'(0));
        check("rst_vec",   {1'b0, out_vec}, 256'(0));
        check("rst_beats", 256'(out_beats), 256'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", 256'(in_ready), 256'(1));

        // 1: full ones
        send_n(32, 8'hFF, 1'b0);
        expect_vec("ones", {255{1'b1}}, 32, 255);
        drain("ones");

        // 2: sparse bits every 8th position
        exp_v = '0;
        for (int k = 0; k < 32; k++) exp_v[k*8] = 1'b1;
        send_n(32, 8'h01, 1'b0);
        expect_vec("sparse", exp_v, 32, 32);
        drain("sparse");

        // 3: early last, then a zero vector to expose stale bits
        send_beat(8'hAA, 1'b0);
        send_beat(8'h55, 1'b0);
        send_beat(8'h0F, 1'b1);
        expect_vec("early", 255'h0F55AA, 3, 12);
        drain("early");
        send_n(32, 8'h00, 1'b0);
        expect_vec("zeros", '0, 32, 0);
        drain("zeros");

        // 4: backpressure with toggling input
        send_n(32, 8'h5A, 1'b0);
        held_vec = rep_byte(8'h5A);
        expect_vec("bp", held_vec, 32, 128);
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_data = (c % 2 == 0) ? 8'hFF : 8'h00;
            in_last = c[0];
            @(negedge clk);
            check("bp_ready", 256'(in_ready), 256'(0));
            check("bp_valid", 256'(out_valid), 256'(1));
            @(posedge clk);
            #1;
            check("bp_vec",   {1'b0, out_vec}, {1'b0, held_vec});
            check("bp_beats", 256'(out_beats), 256'(32));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain("bp");

        // 5: reset mid-fill
        send_n(10, 8'hFF, 1'b0);
        check("mid_valid", 256'(out_valid), 256'(0));
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", 256'(out_valid), 256'(0));
        check("rstmid_vec",   {1'b0, out_vec}, 256'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rstrel_valid", 256'(out_valid), 256'(0));
        check("rstrel_ready", 256'(in_ready), 256'(1));
        send_n(32, 8'h00, 1'b0);
        expect_vec("post_rst", '0, 32, 0);
        drain("post_rst");

        // 6: handshake gaps
        send_n(32, 8'h3C, 1'b1);
        expect_vec("gaps", rep_byte(8'h3C), 32, 128);
        drain("gaps");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
